enc_8b10b_tx: RTL and testbench

Transmit-side 8b/10b encoder with running-disparity tracking and idle (K28.5 comma) insertion. It is the counterpart of the link's 8b/10b receive decoder and produces the 10-bit symbol stream that decoder consumes, in the same bit order. It has a fixed 2-cycle pipeline and supports one symbol per clock.

---
 rtl/enc_8b10b_pkg.sv | 120 ++++++++++++
 rtl/enc_8b10b_tx_if.sv | 31 +++
 rtl/enc_8b10b_core.sv | 62 ++++++
 rtl/enc_8b10b_tx.sv | 118 +++++++++++
 tb/tb_enc_8b10b_tx.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/enc_8b10b_pkg.sv
// enc_8b10b_pkg: shared types, constants and code tables for the 8b/10b transmit encoder.
//   Sub-block tables are written in transmission-letter order (MSB = first letter, i.e.
//   'a' for the 6b block and 'f' for the 4b block) so they read like the published tables.
//   rev6()/rev4() map them onto the dataout bit order (bit0 = a ... bit9 = j).
package enc_8b10b_pkg;

  typedef logic [7:0] data_byte_t;
  typedef logic [9:0] code_t;

  // Kind of request held in stage 1.
  typedef enum logic [1:0] {
    ReqBubble,
    ReqSym,
    ReqIdle
  } req_e;

  localparam data_byte_t IDLE_CODE = 8'hBC;
  localparam code_t      K28_5_RDN = 10'h17C;
  localparam code_t      K28_5_RDP = 10'h283;

  // K28 6b sub-block taken from the RD- comma, converted to letter order.
  localparam logic [5:0] K28_6B_RDN = 6'b001111;

  // D.x.7 primary and alternate 4b codes (RD- column, letter order fghj).
  localparam logic [3:0] P7_4B_RDN = 4'b1110;
  localparam logic [3:0] A7_4B_RDN = 4'b0111;

  // 5b/6b table, RD- column, abcdei.
  function automatic logic [5:0] d6_rdn(input logic [4:0] x);
    logic [5:0] c;
    unique case (x)
      5'd0:    c = 6'b100111;
      5'd1:    c = 6'b011101;
      5'd2:    c = 6'b101101;
      5'd3:    c = 6'b110001;
      5'd4:    c = 6'b110101;
      5'd5:    c = 6'b101001;
      5'd6:    c = 6'b011001;
      5'd7:    c = 6'b111000;
      5'd8:    c = 6'b111001;
      5'd9:    c = 6'b100101;
      5'd10:   c = 6'b010101;
      5'd11:   c = 6'b110100;
      5'd12:   c = 6'b001101;
      5'd13:   c = 6'b101100;
      5'd14:   c = 6'b011100;
      5'd15:   c = 6'b010111;
      5'd16:   c = 6'b011011;
      5'd17:   c = 6'b100011;
      5'd18:   c = 6'b010011;
      5'd19:   c = 6'b110010;
      5'd20:   c = 6'b001011;
      5'd21:   c = 6'b101010;
      5'd22:   c = 6'b011010;
      5'd23:   c = 6'b111010;
      5'd24:   c = 6'b110011;
      5'd25:   c = 6'b100110;
      5'd26:   c = 6'b010110;
      5'd27:   c = 6'b110110;
      5'd28:   c = 6'b001110;
      5'd29:   c = 6'b101110;
      5'd30:   c = 6'b011110;
      default: c = 6'b101011;
    endcase
    return c;
  endfunction

  // 3b/4b data table, RD- column, fghj (y = 7 is the primary P7 code).
  function automatic logic [3:0] d4_rdn(input logic [2:0] y);
    logic [3:0] c;
    unique case (y)
      3'd0:    c = 4'b1011;
      3'd1:    c = 4'b1001;
      3'd2:    c = 4'b0101;
      3'd3:    c = 4'b1100;
      3'd4:    c = 4'b1101;
      3'd5:    c = 4'b1010;
      3'd6:    c = 4'b0110;
      default: c = P7_4B_RDN;
    endcase
    return c;
  endfunction

  // 3b/4b control table, RD- column, fghj. Every entry is complemented at RD+,
  // balanced ones included, which is what makes K28.y differ from D28.y.
  function automatic logic [3:0] k4_rdn(input logic [2:0] y);
    logic [3:0] c;
    unique case (y)
      3'd0:    c = 4'b1011;
      3'd1:    c = 4'b0110;
      3'd2:    c = 4'b1010;
      3'd3:    c = 4'b1100;
      3'd4:    c = 4'b1101;
      3'd5:    c = 4'b0101;
      3'd6:    c = 4'b1001;
      default: c = A7_4B_RDN;
    endcase
    return c;
  endfunction

  function automatic logic is_legal_k(input data_byte_t b);
    logic [4:0] x;
    x = b[4:0];
    return (x == 5'd28) ||
           ((b[7:5] == 3'd7) && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
  endfunction

  function automatic logic [5:0] rev6(input logic [5:0] v);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = v[5-i];
    return r;
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = v[3-i];
    return r;
  endfunction

endpackage

// File: rtl/enc_8b10b_tx_if.sv
// enc_8b10b_tx_if: request/symbol bundle of the 8b/10b transmit encoder.
//   Request (master -> slave): ena, datain[7:0], kin, idle_ins, rdforce, rdin.
//   Symbol  (slave -> master): valid, dataout[9:0], kout, idle, kerr, rdout.
interface enc_8b10b_tx_if;
  import enc_8b10b_pkg::*;

  logic       ena;
  data_byte_t datain;
  logic       kin;
  logic       idle_ins;
  logic       rdforce;
  logic       rdin;

  logic       valid;
  code_t      dataout;
  logic       kout;
  logic       idle;
  logic       kerr;
  logic       rdout;

  modport master (
    output ena, datain, kin, idle_ins, rdforce, rdin,
    input  valid, dataout, kout, idle, kerr, rdout
  );

  modport slave (
    input  ena, datain, kin, idle_ins, rdforce, rdin,
    output valid, dataout, kout, idle, kerr, rdout
  );

endinterface

// File: rtl/enc_8b10b_core.sv
// enc_8b10b_core: combinational 8b/10b symbol encoder.
//   byte_i  : byte to encode ([7:5] = y, [4:0] = x)
//   k_i     : encode as control character
//   rd_i    : running disparity before the symbol (0 = RD-, 1 = RD+)
//   code_o  : 10-bit symbol, bit0 = a ... bit5 = i, bit6 = f ... bit9 = j
//   rd_o    : running disparity after the symbol
//   kerr_o  : k_i set with a byte outside the legal control set (encoded as data)
module enc_8b10b_core
  import enc_8b10b_pkg::*;
(
  input  data_byte_t byte_i,
  input  logic       k_i,
  input  logic       rd_i,
  output code_t      code_o,
  output logic       rd_o,
  output logic       kerr_o
);

  logic [4:0] x;
  logic [2:0] y;
  logic       use_k, is_k28, is_d7, alt7;
  logic       bal6, bal4, compl4, rd6;
  logic [5:0] six_n, six;
  logic [3:0] four_n, four;

  assign x = byte_i[4:0];
  assign y = byte_i[7:5];

  always_comb begin
    kerr_o = k_i & ~is_legal_k(byte_i);
    use_k  = k_i & ~kerr_o;
    is_k28 = use_k && (x == 5'd28);
    // Legal K with x != 28 never has x == 7, so this only catches data-encoded D.7.
    is_d7  = !is_k28 && (x == 5'd7);

    six_n  = is_k28 ? K28_6B_RDN : d6_rdn(x);
    bal6   = ($countones(six_n) == 3);
    // D.7 is balanced yet still has distinct RD-/RD+ forms.
    six    = (rd_i && (!bal6 || is_d7)) ? ~six_n : six_n;
    rd6    = rd_i ^ ~bal6;

    // Alternate 7 avoids a run of five equal bits across the sub-block boundary.
    alt7   = (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
             ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));

    if (use_k) begin
      four_n = k4_rdn(y);
    end else if (y == 3'd7) begin
      four_n = alt7 ? A7_4B_RDN : P7_4B_RDN;
    end else begin
      four_n = d4_rdn(y);
    end
    bal4   = ($countones(four_n) == 2);
    // D.x.3 is balanced but RD-dependent; control codes always flip at RD+.
    compl4 = use_k || !bal4 || (y == 3'd3);
    four   = (rd6 && compl4) ? ~four_n : four_n;
    rd_o   = rd6 ^ ~bal4;

    code_o = {rev4(four), rev6(six)};
  end

endmodule

// File: rtl/enc_8b10b_tx.sv
// enc_8b10b_tx: two-stage 8b/10b transmit encoder with running disparity and idle insertion.
//   clk     : clock, rising edge
//   reset_n : asynchronous reset, active high
//   bus     : request inputs and registered symbol outputs (see enc_8b10b_tx_if)
// Stage 1 registers the request; stage 2 encodes it and registers the symbol. The RD
// register feeds straight back into stage 2, so back-to-back symbols chain correctly.
module enc_8b10b_tx
  import enc_8b10b_pkg::*;
(
  input logic             clk,
  input logic             reset_n,
  enc_8b10b_tx_if.slave   bus
);

  // Stage 1
  req_e       req_d, req_q;
  data_byte_t byte_d, byte_q;
  logic       kin_d, kin_q;
  logic       force_d, force_q;
  logic       rdin_d, rdin_q;

  // Stage 2 (rd_q is both the RD register and the rdout output)
  logic       valid_d, valid_q;
  code_t      code_d, code_q;
  logic       kout_d, kout_q;
  logic       idle_d, idle_q;
  logic       kerr_d, kerr_q;
  logic       rd_d, rd_q;

  code_t      core_code;
  logic       core_rd, core_kerr, rd_cur;

  always_comb begin
    req_d   = ReqBubble;
    byte_d  = byte_q;
    kin_d   = kin_q;
    force_d = force_q;
    rdin_d  = rdin_q;
    if (bus.ena) begin
      req_d   = ReqSym;
      byte_d  = bus.datain;
      kin_d   = bus.kin;
      force_d = bus.rdforce;
      rdin_d  = bus.rdin;
    end else if (bus.idle_ins) begin
      req_d   = ReqIdle;
      byte_d  = IDLE_CODE;
      kin_d   = 1'b1;
      force_d = 1'b0;
      rdin_d  = 1'b0;
    end
  end

  assign rd_cur = force_q ? rdin_q : rd_q;

  enc_8b10b_core u_core (
    .byte_i (byte_q),
    .k_i    (kin_q),
    .rd_i   (rd_cur),
    .code_o (core_code),
    .rd_o   (core_rd),
    .kerr_o (core_kerr)
  );

  // Bubbles hold every output and the RD register; only valid drops.
  always_comb begin
    valid_d = 1'b0;
    code_d  = code_q;
    kout_d  = kout_q;
    idle_d  = idle_q;
    kerr_d  = kerr_q;
    rd_d    = rd_q;
    if (req_q != ReqBubble) begin
      valid_d = 1'b1;
      code_d  = core_code;
      kout_d  = kin_q & ~core_kerr;
      idle_d  = (req_q == ReqIdle);
      kerr_d  = core_kerr;
      rd_d    = core_rd;
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      req_q   <= ReqBubble;
      byte_q  <= '0;
      kin_q   <= 1'b0;
      force_q <= 1'b0;
      rdin_q  <= 1'b0;
      valid_q <= 1'b0;
      code_q  <= '0;
      kout_q  <= 1'b0;
      idle_q  <= 1'b0;
      kerr_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      req_q   <= req_d;
      byte_q  <= byte_d;
      kin_q   <= kin_d;
      force_q <= force_d;
      rdin_q  <= rdin_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      kout_q  <= kout_d;
      idle_q  <= idle_d;
      kerr_q  <= kerr_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.valid   = valid_q;
  assign bus.dataout = code_q;
  assign bus.kout    = kout_q;
  assign bus.idle    = idle_q;
  assign bus.kerr    = kerr_q;
  assign bus.rdout   = rd_q;

endmodule

// File: tb/tb_enc_8b10b_tx.sv
// tb_enc_8b10b_tx: directed vectors with hand-computed symbols, plus a random stream whose
// sub-block disparities and RD chain are checked against a bench-side RD tracker.
module tb_enc_8b10b_tx;
  import enc_8b10b_pkg::*;

  localparam logic [1:0] ModeSkip  = 2'd0;
  localparam logic [1:0] ModeExact = 2'd1;
  localparam logic [1:0] ModeProp  = 2'd2;

  typedef struct packed {
    logic [1:0] mode;
    logic       valid;
    logic [9:0] code;
    logic       kout;
    logic       idle;
    logic       kerr;
    logic       rd;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  enc_8b10b_tx_if bus ();

  enc_8b10b_tx dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         vec_idx = 0;
  logic       rd_model = 1'b0;
  logic [7:0] klist [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                             8'hF7, 8'hFB, 8'hFD, 8'hFE};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  function automatic exp_t ex(input logic v, input logic [9:0] c, input logic k,
                              input logic i, input logic e, input logic r);
    return {ModeExact, v, c, k, i, e, r};
  endfunction

  function automatic exp_t exk(input logic k);
    exp_t e;
    e = '0;
    e.mode = ModeProp;
    e.kout = k;
    return e;
  endfunction

  task automatic score(input exp_t e);
    string t;
    int    o6, o4;
    logic  bad, r;
    t = $sformatf("v%0d", vec_idx);
    vec_idx++;
    if (e.mode == ModeExact) begin
      check({t, ".valid"},   32'(bus.valid),   32'(e.valid));
      check({t, ".dataout"}, 32'(bus.dataout), 32'(e.code));
      check({t, ".kout"},    32'(bus.kout),    32'(e.kout));
      check({t, ".idle"},    32'(bus.idle),    32'(e.idle));
      check({t, ".kerr"},    32'(bus.kerr),    32'(e.kerr));
      check({t, ".rdout"},   32'(bus.rdout),   32'(e.rd));
    end else if (e.mode == ModeProp) begin
      check({t, ".valid"}, 32'(bus.valid), 32'd1);
      check({t, ".kout"},  32'(bus.kout),  32'(e.kout));
      check({t, ".kerr"},  32'(bus.kerr),  32'd0);
      bad = 1'b0;
      r   = rd_model;
      o6  = $countones(bus.dataout[5:0]);
      o4  = $countones(bus.dataout[9:6]);
      if (o6 == 4) begin
        if (r) bad = 1'b1;
        r = 1'b1;
      end else if (o6 == 2) begin
        if (!r) bad = 1'b1;
        r = 1'b0;
      end else if (o6 != 3) begin
        bad = 1'b1;
      end
      if (o4 == 3) begin
        if (r) bad = 1'b1;
        r = 1'b1;
      end else if (o4 == 1) begin
        if (!r) bad = 1'b1;
        r = 1'b0;
      end else if (o4 != 2) begin
        bad = 1'b1;
      end
      check({t, ".disp"}, 32'(bad), 32'd0);
      rd_model = r;
      check({t, ".rdout"}, 32'(bus.rdout), 32'(rd_model));
    end
  endtask

  // A request driven at one falling edge is visible two falling edges later.
  task automatic drive(input logic a_ena, input logic [7:0] a_d, input logic a_k,
                       input logic a_idle, input logic a_force, input logic a_rdin,
                       input exp_t e);
    @(negedge clk);
    if (exp_q.size() == 2) score(exp_q.pop_front());
    bus.ena      = a_ena;
    bus.datain   = a_d;
    bus.kin      = a_k;
    bus.idle_ins = a_idle;
    bus.rdforce  = a_force;
    bus.rdin     = a_rdin;
    exp_q.push_back(e);
  endtask

  task automatic flush();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string t);
    check({t, ".valid"},   32'(bus.valid),   32'd0);
    check({t, ".dataout"}, 32'(bus.dataout), 32'd0);
    check({t, ".kout"},    32'(bus.kout),    32'd0);
    check({t, ".idle"},    32'(bus.idle),    32'd0);
    check({t, ".kerr"},    32'(bus.kerr),    32'd0);
    check({t, ".rdout"},   32'(bus.rdout),   32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       k;

    bus.ena = 1'b0; bus.datain = 8'h00; bus.kin = 1'b0;
    bus.idle_ins = 1'b0; bus.rdforce = 1'b0; bus.rdin = 1'b0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    reset_n = 1'b0;

    // Idle insertion alternates the comma starting from RD-.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0,
            ex(1'b1, (i % 2 == 0) ? K28_5_RDN : K28_5_RDP, 1'b1, 1'b1, 1'b0, (i % 2 == 0)));
    end
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, 10'h0B9, 1'b0, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, 10'h0B9, 1'b0, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, 10'h155, 1'b0, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, 10'h17C, 1'b1, 1'b0, 1'b0, 1'b1));
    // Illegal K byte, forced to RD-: data encoding with kerr.
    drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, ex(1'b1, 10'h0B9, 1'b0, 1'b0, 1'b1, 1'b0));
    drive(1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1, ex(1'b1, 10'h283, 1'b1, 1'b0, 1'b0, 1'b0));
    // D.7.0 at RD-, then a 3-cycle gap that must hold everything.
    drive(1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, 10'h347, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 10'h347, 1'b0, 1'b0, 1'b0, 1'b1));
    end
    drive(1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, 10'h0B8, 1'b0, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 8'hF1, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, 10'h3B1, 1'b0, 1'b0, 1'b0, 1'b1));
    drive(1'b1, 8'hEB, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, 10'h04B, 1'b0, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 8'h63, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, 10'h0E3, 1'b0, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 8'hFC, 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, 10'h07C, 1'b1, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 8'hF7, 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, 10'h057, 1'b1, 1'b0, 1'b0, 1'b0));
    // ena wins over idle_ins.
    drive(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, ex(1'b1, 10'h0B9, 1'b0, 1'b0, 1'b0, 1'b0));
    flush();

    // Reset in the middle of a stream clears outputs without a clock edge.
    @(negedge clk);
    bus.ena = 1'b1; bus.datain = 8'hBC; bus.kin = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_rst.valid", 32'(bus.valid), 32'd1);
    #1;
    reset_n = 1'b1;
    #1;
    check_reset_values("mid_rst");
    bus.ena = 1'b0; bus.kin = 1'b0; bus.datain = 8'h00;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("post_rst.valid", 32'(bus.valid), 32'd0);
    drive(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, 10'h17C, 1'b1, 1'b0, 1'b0, 1'b1));
    flush();

    // Random back-to-back D/K stream; RD is tracked from the emitted symbols.
    rd_model = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      k = ($urandom_range(0, 7) == 0);
      d = k ? klist[$urandom_range(0, 11)] : 8'($urandom);
      drive(1'b1, d, k, 1'b0, 1'b0, 1'b0, exk(k));
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
